muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq.sv | 107 ++++++++++
 tb/tb_muldiv_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequencer that hands a multiply or divide to the external
// arithmetic unit, waits for its completion, then either loads HI/LO or
// raises an exception (divide-by-zero or unit timeout).
module muldiv_seq #(
   parameter int TIMEOUT = 40,
   parameter int CNT_W   = 6
) (
   input  logic clk,
   input  logic reset,
   input  logic mult_req,
   input  logic div_req,
   input  logic mult_done,
   input  logic div_done,
   input  logic div_zero,
   output logic mult_init,
   output logic div_init,
   output logic hilo_sel,
   output logic high_load,
   output logic low_load,
   output logic busy,
   output logic done,
   output logic div_zero_exc,
   output logic timeout_exc
);

   typedef enum logic [1:0] {IDLE, RUN, WRITE, EXC} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t           state, state_nxt;
   logic             op, op_nxt;           // 0 = multiply, 1 = divide
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             exc_to, exc_to_nxt;   // EXC cause: 1 = timeout, 0 = div-by-zero
   logic             match_done;

   // The completion that counts is the one from the unit actually running.
   assign match_done = op ? div_done : mult_done;

   // State, operation, counter and exception-cause registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         op     <= 1'b0;
         cnt    <= '0;
         exc_to <= 1'b0;
      end else begin
         state  <= state_nxt;
         op     <= op_nxt;
         cnt    <= cnt_nxt;
         exc_to <= exc_to_nxt;
      end
   end

   // Next-state logic; op is only rewritten on accepting a request so it
   // keeps the last operation while idle (drives hilo_sel).
   always_comb begin
      state_nxt  = state;
      op_nxt     = op;
      cnt_nxt    = cnt;
      exc_to_nxt = exc_to;
      unique case (state)
         IDLE: begin
            // Multiply has priority; a simultaneous divide request is dropped.
            if (mult_req) begin
               op_nxt    = 1'b0;
               cnt_nxt   = '0;
               state_nxt = RUN;
            end else if (div_req) begin
               op_nxt    = 1'b1;
               cnt_nxt   = '0;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (cnt != CNT_MAX) cnt_nxt = cnt + CNT_W'(1);
            // The cnt==0 cycle is the init pulse; a done seen there is stale.
            if (cnt != '0 && match_done) begin
               if (op && div_zero) begin
                  exc_to_nxt = 1'b0;
                  state_nxt  = EXC;
               end else begin
                  state_nxt  = WRITE;
               end
            end else if (cnt == CNT_LAST) begin
               exc_to_nxt = 1'b1;
               state_nxt  = EXC;
            end
         end
         WRITE:   state_nxt = IDLE;
         EXC:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Moore outputs decoded from registered state only.
   assign mult_init    = (state == RUN) && (cnt == '0) && !op;
   assign div_init     = (state == RUN) && (cnt == '0) &&  op;
   assign hilo_sel     = op;
   assign high_load    = (state == WRITE);
   assign low_load     = (state == WRITE);
   assign done         = (state == WRITE);
   assign busy         = (state != IDLE);
   assign div_zero_exc = (state == EXC) && !exc_to;
   assign timeout_exc  = (state == EXC) &&  exc_to;

endmodule

// File: tb/tb_muldiv_seq.sv
// Testbench for muldiv_seq: directed vector table, randomized operations
// checked against a transaction-level outcome model, and hand-written
// reset / request-filtering sequences.
module tb_muldiv_seq;

   localparam int TIMEOUT = 40;
   localparam int K_WR = 0, K_DZ = 1, K_TO = 2;

   logic clk = 1'b0;
   logic reset, mult_req, div_req, mult_done, div_done, div_zero;
   logic mult_init, div_init, hilo_sel, high_load, low_load, busy, done;
   logic div_zero_exc, timeout_exc;

   int n_cmp = 0;
   int n_bad = 0;

   muldiv_seq #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .mult_req(mult_req), .div_req(div_req),
      .mult_done(mult_done), .div_done(div_done), .div_zero(div_zero),
      .mult_init(mult_init), .div_init(div_init), .hilo_sel(hilo_sel),
      .high_load(high_load), .low_load(low_load), .busy(busy), .done(done),
      .div_zero_exc(div_zero_exc), .timeout_exc(timeout_exc)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit is_div;
      bit both;
      int dly;       // RUN cycle (cnt value) in which the matching done is pulsed
      bit zero;
      int wrong_at;  // RUN cycle of a non-matching done pulse, -1 = none
      int kind;
      int k;         // RUN-relative cycle of the outcome pulse
   } vec_t;

   vec_t tbl[13];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Outcome model: the matching done is honoured once the unit has been
   // started (cycle >= 1) and before the timeout window closes.
   function automatic void predict(input bit eff_div, input int dly, input bit zero,
                                   output int kind, output int k);
      if (dly >= 1 && dly <= TIMEOUT - 1) begin
         kind = (eff_div && zero) ? K_DZ : K_WR;
         k    = dly + 1;
      end else begin
         kind = K_TO;
         k    = TIMEOUT;
      end
   endfunction

   function automatic logic [8:0] outs();
      return {mult_init, div_init, hilo_sel, high_load, low_load, busy, done,
              div_zero_exc, timeout_exc};
   endfunction

   task automatic clear_in();
      mult_req = 0; div_req = 0; mult_done = 0; div_done = 0; div_zero = 0;
   endtask

   task automatic run_op(input string tag, input bit is_div, input bit both, input int dly,
                         input bit zero, input int wrong_at, input int kind, input int exp_k);
      bit eff_div;
      bit ended;
      int n_mi, n_di, n_busy, n_done, n_hl, n_ll, n_dz, n_to, out_k, init_k, hs_bad;
      eff_div = is_div && !both;
      ended = 0;
      n_mi = 0; n_di = 0; n_busy = 0; n_done = 0; n_hl = 0; n_ll = 0;
      n_dz = 0; n_to = 0; out_k = -1; init_k = -1; hs_bad = 0;
      @(negedge clk);
      check({tag, "_idle_before"}, int'(busy), 0);
      mult_req = !is_div || both;
      div_req  = is_div || both;
      @(negedge clk);
      clear_in();
      for (int k = 0; k < 80; k++) begin
         if (k > 0) @(negedge clk);
         if (!busy) begin
            ended = 1;
            break;
         end
         n_busy++;
         if (mult_init) begin n_mi++; init_k = k; end
         if (div_init)  begin n_di++; init_k = k; end
         if (done)         begin n_done++; out_k = k; end
         if (div_zero_exc) begin n_dz++;   out_k = k; end
         if (timeout_exc)  begin n_to++;   out_k = k; end
         if (high_load) n_hl++;
         if (low_load)  n_ll++;
         if (hilo_sel != eff_div) hs_bad++;
         clear_in();
         if (k == dly) begin
            if (eff_div) div_done = 1; else mult_done = 1;
            div_zero = zero;
         end
         if (k == wrong_at) begin
            if (eff_div) mult_done = 1;
            else begin div_done = 1; div_zero = 1; end
         end
         // A request while busy must be ignored, not queued.
         if (k == 2) begin
            if (eff_div) mult_req = 1; else div_req = 1;
         end
      end
      clear_in();
      if (!ended) check({tag, "_busy_bound"}, 1, 0);
      check({tag, "_init_cycle"}, init_k, 0);
      check({tag, "_mult_init_cnt"}, n_mi, eff_div ? 0 : 1);
      check({tag, "_div_init_cnt"}, n_di, eff_div ? 1 : 0);
      check({tag, "_done_cnt"}, n_done, (kind == K_WR) ? 1 : 0);
      check({tag, "_high_load_cnt"}, n_hl, (kind == K_WR) ? 1 : 0);
      check({tag, "_low_load_cnt"}, n_ll, (kind == K_WR) ? 1 : 0);
      check({tag, "_dz_exc_cnt"}, n_dz, (kind == K_DZ) ? 1 : 0);
      check({tag, "_to_exc_cnt"}, n_to, (kind == K_TO) ? 1 : 0);
      check({tag, "_outcome_cycle"}, out_k, exp_k);
      check({tag, "_busy_cycles"}, n_busy, exp_k + 1);
      check({tag, "_hilo_sel_busy"}, hs_bad, 0);
      check({tag, "_hilo_sel_idle"}, int'(hilo_sel), int'(eff_div));
      // A stray request while busy would have started a new op by now.
      @(negedge clk);
      check({tag, "_idle_after"}, int'(busy), 0);
   endtask

   initial begin
      int kind, k, cnt_any, cnt_mi;
      bit r_div, r_both, r_zero;
      int r_dly, r_wrong;

      tbl[0]  = '{0, 0,  5, 0, -1, K_WR,  6};        // basic multiply
      tbl[1]  = '{1, 0,  3, 1, -1, K_DZ,  4};        // divide by zero
      tbl[2]  = '{0, 0, 99, 0, -1, K_TO, TIMEOUT};   // unit never completes
      tbl[3]  = '{0, 1,  4, 0, -1, K_WR,  5};        // mult wins contention
      tbl[4]  = '{1, 0,  3, 0,  1, K_WR,  4};        // wrong-unit done first
      tbl[5]  = '{0, 0,  1, 0, -1, K_WR,  2};        // best-case latency
      tbl[6]  = '{0, 0,  0, 0, -1, K_TO, TIMEOUT};   // done in init cycle ignored
      tbl[7]  = '{1, 0, 39, 0, -1, K_WR, 40};        // completion beats timeout
      tbl[8]  = '{1, 0, 40, 0, -1, K_TO, TIMEOUT};   // one cycle too late
      tbl[9]  = '{0, 0,  2, 1, -1, K_WR,  3};        // div_zero irrelevant to mult
      tbl[10] = '{1, 0, 39, 1, -1, K_DZ, 40};        // div-by-zero at last cycle
      tbl[11] = '{0, 0,  7, 0,  3, K_WR,  8};        // div_done+zero during mult
      tbl[12] = '{1, 0,  1, 0, -1, K_WR,  2};        // fastest divide

      clear_in();
      reset = 1;
      repeat (3) @(negedge clk);
      check("reset_outputs", int'(outs()), 0);

      // Request coinciding with reset is discarded.
      mult_req = 1;
      @(negedge clk);
      reset = 0;
      mult_req = 0;
      @(negedge clk);
      check("req_in_reset_busy", int'(busy), 0);
      check("req_in_reset_init", int'(mult_init), 0);

      foreach (tbl[i])
         run_op($sformatf("vec%0d", i), tbl[i].is_div, tbl[i].both, tbl[i].dly,
                tbl[i].zero, tbl[i].wrong_at, tbl[i].kind, tbl[i].k);

      // Last table op was a divide: reset while idle must clear hilo_sel.
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      check("reset_idle_outputs", int'(outs()), 0);

      for (int i = 0; i < 20; i++) begin
         r_div   = 1'($urandom_range(0, 1));
         r_both  = ($urandom_range(0, 3) == 0);
         r_dly   = $urandom_range(0, 45);
         r_zero  = 1'($urandom_range(0, 1));
         r_wrong = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 45)) : -1;
         predict(r_div && !r_both, r_dly, r_zero, kind, k);
         run_op($sformatf("rnd%0d", i), r_div, r_both, r_dly, r_zero, r_wrong, kind, k);
      end

      // Reset in RUN cycle cnt==3, then a late mult_done: nothing may follow.
      @(negedge clk);
      cnt_mi = 0;
      mult_req = 1;
      @(negedge clk);
      mult_req = 0;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk);
         if (mult_init) cnt_mi++;
      end
      reset = 1;
      @(negedge clk);
      reset = 0;
      check("mid_reset_outputs", int'(outs()), 0);
      mult_done = 1;
      cnt_any = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         mult_done = 0;
         if (mult_init) cnt_mi++;
         if (busy | done | high_load | low_load | div_zero_exc | timeout_exc | div_init)
            cnt_any++;
      end
      check("mid_reset_quiet", cnt_any, 0);
      check("mid_reset_init_cnt", cnt_mi, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
